alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequencing front end for the 16-bit combinational ALU: accepts instructions over a valid/ready command port, reads operands from an internal 8×16 register file, and drives `opcode`/`x`/`y` into the ALU. After a fixed settle window it captures `r` and the ALU flags, writes the result back, and maintains an architectural NZCV status register plus a sticky divide-fault bit. It is the initiating side of the ALU's opcode/operand/flag interface and sits between the instruction decoder and the ALU instance.

## Interface
- `WIDTH`, 16: datapath width; must match the ALU.
- `ALU_SETTLE`, 2: cycles operands are held stable on the ALU before capture; legal range 1–15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the block accepts a command this cycle.
- `cmd_opcode` in 5: ALU opcode.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2` in 3 each: destination and source register indices.
- `cmd_imm_en` in 1: use `cmd_imm` instead of `rs2` as `y`.
- `cmd_imm` in WIDTH: immediate operand.
- `alu_opcode` out 5, `alu_x` out WIDTH, `alu_y` out WIDTH: registered drive to the ALU.
- `alu_r` in WIDTH; `alu_overflow`, `alu_negative`, `alu_zero`, `alu_cout`, `alu_div_invalid` in 1 each: ALU results.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out WIDTH: captured result.
- `rsp_err` out 1: qualifies `rsp_valid`; signals an illegal opcode or a divide fault.
- `flags_nzcv` out 4: status register {N,Z,C,V}.
- `div_fault` out 1: sticky divide-fault bit.
- `clr_fault` in 1: clears `div_fault`.

## Operation
- Legal opcodes: 00000–10000, 11000–11100, 11110.
- Illegal opcodes: 10001–10111, 11101, 11111. An illegal command is not issued to the ALU. It goes IDLE→WB directly with `rsp_err`=1, `rsp_data`=0, no writeback and no flag change.
- Compare opcodes 00101 and 11110: flags are updated; no register writeback.
- Divide fault:
  - Opcode 01101 faults when `alu_div_invalid`=1 at capture.
  - Opcode 01110 faults when the `y` operand = 0, checked locally.
  - On a fault there is no writeback and no flag change, `rsp_err`=1, and `div_fault` is set.
- All other legal opcodes: write `alu_r` to `rd` and load `flags_nzcv` from the ALU flags.
- Register r0 always reads 0; writes to r0 are dropped. The flag update still happens.
- FSM:
  - IDLE: `cmd_ready`=1. On a handshake, latch the opcode, the `rs1` value, the `rs2`/`imm` value and `rd`, then go to EXEC (legal opcode) or WB (illegal opcode).
  - EXEC: a down-counter loads `ALU_SETTLE` and decrements each cycle. When it reaches 1, capture `alu_r`, the flags and `alu_div_invalid`, then go to WB.
  - WB: `rsp_valid`=1. The regfile write, flag update and fault set take effect at the end of this cycle. Return to IDLE.
- `alu_opcode`, `alu_x` and `alu_y` hold the latched values from accept until the next accept. When idle they do not toggle.
- `clr_fault` coinciding with a new fault in the same cycle: the set wins.

## Timing
- Reset values:
  - `cmd_ready`=0 while `rst_n`=0, then 1 on the first cycle after reset.
  - `rsp_valid`, `rsp_err`, `rsp_data`, `alu_*` outputs, `flags_nzcv`, `div_fault` and all registers reset to 0; FSM resets to IDLE.
- Legal op accepted at cycle t:
  - EXEC occupies t+1 … t+ALU_SETTLE.
  - `rsp_valid` at t+ALU_SETTLE+1.
  - Next accept possible at t+ALU_SETTLE+2.
- Illegal op accepted at t: `rsp_valid` at t+1.
- A result written in WB is visible to a command accepted in the following IDLE cycle. No hazard logic is needed.
- Reset asserted mid-operation aborts the operation at the next edge: no writeback, no `rsp_valid`.
- `rsp_valid` has no backpressure.

## Configuration
- `ALU_ISSUE_CNT_EN` defined: adds outputs `cnt_issued` (32) and `cnt_faults` (16).
  - `cnt_issued` counts every `rsp_valid`.
  - `cnt_faults` counts every `rsp_err`.
  - Both saturate, reset to 0, and increment in the WB cycle.
- `ALU_ISSUE_CNT_EN` undefined: the counters and their ports are absent; all other behaviour is identical.

## Structure
- Shared `alu_pkg`:
  - opcode localparams (OP_MOV … OP_SCMP)
  - FSM state enum {IDLE, EXEC, WB}
  - NZCV bit-index constants
  - an `is_legal_op` function and an `is_cmp_op` function
- One sub-module, `alu_regfile`: 8×WIDTH registers, two combinational read ports, one synchronous write port, r0 forced to zero.

## Test plan
- r1=5, r2=3, ADD (00001) rd=r3 → `rsp_valid` 3 cycles after accept (ALU_SETTLE=2); r3=8; `flags_nzcv`=0000.
- CMP (00101) r1=3 vs r2=3 with ALU zero=1 → r0–r7 unchanged; `flags_nzcv`=0100; `rsp_data`=0.
- DIV (01101) r1=10 by r2=0 with `alu_div_invalid`=1 → `rsp_err`=1, `div_fault`=1, rd unchanged, flags unchanged; `clr_fault` then clears `div_fault`.
- Opcode 11101 → `rsp_valid`+`rsp_err` 1 cycle after accept; `alu_opcode` unchanged.
- Back-to-back: ADD rd=r4, then MOV (00000) with rs1=r4 accepted in the first IDLE cycle → the MOV result equals the new r4.
- `rst_n` low during EXEC of an ADD to r5 → no `rsp_valid`; r5=0; `cmd_ready`=1 the cycle after reset is released.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front end: opcodes, FSM states,
// NZCV bit positions and opcode classification helpers.
package alu_pkg;

   localparam logic [4:0] OP_MOV  = 5'b00000;
   localparam logic [4:0] OP_ADD  = 5'b00001;
   localparam logic [4:0] OP_SUB  = 5'b00010;
   localparam logic [4:0] OP_ADC  = 5'b00011;
   localparam logic [4:0] OP_SBC  = 5'b00100;
   localparam logic [4:0] OP_CMP  = 5'b00101;
   localparam logic [4:0] OP_AND  = 5'b00110;
   localparam logic [4:0] OP_OR   = 5'b00111;
   localparam logic [4:0] OP_XOR  = 5'b01000;
   localparam logic [4:0] OP_NOT  = 5'b01001;
   localparam logic [4:0] OP_SHL  = 5'b01010;
   localparam logic [4:0] OP_SHR  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01100;
   localparam logic [4:0] OP_DIV  = 5'b01101;
   localparam logic [4:0] OP_MOD  = 5'b01110;
   localparam logic [4:0] OP_NEG  = 5'b01111;
   localparam logic [4:0] OP_ASR  = 5'b10000;
   localparam logic [4:0] OP_ROL  = 5'b11000;
   localparam logic [4:0] OP_ROR  = 5'b11001;
   localparam logic [4:0] OP_INC  = 5'b11010;
   localparam logic [4:0] OP_DEC  = 5'b11011;
   localparam logic [4:0] OP_ABS  = 5'b11100;
   localparam logic [4:0] OP_SCMP = 5'b11110;

   localparam int NZCV_N = 3;
   localparam int NZCV_Z = 2;
   localparam int NZCV_C = 1;
   localparam int NZCV_V = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   function automatic logic is_legal_op(input logic [4:0] op);
      return (op <= OP_ASR) || ((op >= OP_ROL) && (op <= OP_ABS)) || (op == OP_SCMP);
   endfunction

   function automatic logic is_cmp_op(input logic [4:0] op);
      return (op == OP_CMP) || (op == OP_SCMP);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8-entry register file: two combinational read ports, one synchronous
// write port; entry 0 is hard-wired to zero.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [2:0]       waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [2:0]       raddr1,
   output logic [WIDTH-1:0] rdata1,
   input  logic [2:0]       raddr2,
   output logic [WIDTH-1:0] rdata2
);

   logic [7:0][WIDTH-1:0] rf;

   for (genvar gi = 0; gi < 8; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
         assign rf[gi] = '0;
      end else begin : g_word
         logic [WIDTH-1:0] q_reg;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               q_reg <= '0;
            end else if (we && (waddr == 3'(gi))) begin
               q_reg <= wdata;
            end
         end
         assign rf[gi] = q_reg;
      end
   end

   assign rdata1 = rf[raddr1];
   assign rdata2 = rf[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing front end for the 16-bit combinational ALU.
// Optional ALU_ISSUE_CNT_EN adds saturating cnt_issued / cnt_faults outputs.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int ALU_SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [4:0]       cmd_opcode,
   input  logic [2:0]       cmd_rd,
   input  logic [2:0]       cmd_rs1,
   input  logic [2:0]       cmd_rs2,
   input  logic             cmd_imm_en,
   input  logic [WIDTH-1:0] cmd_imm,
   output logic [4:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   input  logic [WIDTH-1:0] alu_r,
   input  logic             alu_overflow,
   input  logic             alu_negative,
   input  logic             alu_zero,
   input  logic             alu_cout,
   input  logic             alu_div_invalid,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output logic [3:0]       flags_nzcv,
   output logic             div_fault,
   input  logic             clr_fault
`ifdef ALU_ISSUE_CNT_EN
   ,
   output logic [31:0]      cnt_issued,
   output logic [15:0]      cnt_faults
`endif
);

   state_t           state_reg, state_next;
   logic [3:0]       cnt_reg;
   logic [4:0]       op_reg;
   logic [WIDTH-1:0] x_reg, y_reg;
   logic [2:0]       rd_reg;
   logic [WIDTH-1:0] result_reg;
   logic [3:0]       nzcv_cap_reg;
   logic             illegal_reg;
   logic             fault_reg;
   logic [3:0]       flags_reg;
   logic             div_fault_reg;

   logic             accept;
   logic             cmd_legal;
   logic             capture;
   logic             fault_now;
   logic             in_wb;
   logic             rf_we;
   logic [WIDTH-1:0] rs1_val, rs2_val, y_val;
   logic [3:0]       nzcv_now;

   alu_regfile #(.WIDTH(WIDTH)) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (rf_we),
      .waddr  (rd_reg),
      .wdata  (result_reg),
      .raddr1 (cmd_rs1),
      .rdata1 (rs1_val),
      .raddr2 (cmd_rs2),
      .rdata2 (rs2_val)
   );

   // cmd_ready is gated by rst_n so it stays low for the whole reset window
   assign cmd_ready = (state_reg == IDLE) && rst_n;
   assign accept    = cmd_valid && cmd_ready;
   assign cmd_legal = is_legal_op(cmd_opcode);
   assign y_val     = cmd_imm_en ? cmd_imm : rs2_val;
   assign capture   = (state_reg == EXEC) && (cnt_reg == 4'd1);
   assign in_wb     = (state_reg == WB);

   // Remainder by zero is detected locally because the ALU only reports divide faults
   assign fault_now = ((op_reg == OP_DIV) && alu_div_invalid) ||
                      ((op_reg == OP_MOD) && (y_reg == '0));

   always_comb begin
      nzcv_now         = '0;
      nzcv_now[NZCV_N] = alu_negative;
      nzcv_now[NZCV_Z] = alu_zero;
      nzcv_now[NZCV_C] = alu_cout;
      nzcv_now[NZCV_V] = alu_overflow;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = cmd_legal ? EXEC : WB;
            end
         end
         EXEC: begin
            if (cnt_reg == 4'd1) begin
               state_next = WB;
            end
         end
         WB:      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Command latch and ALU drive; illegal commands never reach the ALU
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_reg      <= '0;
         x_reg       <= '0;
         y_reg       <= '0;
         rd_reg      <= '0;
         illegal_reg <= 1'b0;
         cnt_reg     <= '0;
      end else if (accept) begin
         rd_reg      <= cmd_rd;
         illegal_reg <= ~cmd_legal;
         cnt_reg     <= 4'(ALU_SETTLE);
         if (cmd_legal) begin
            op_reg <= cmd_opcode;
            x_reg  <= rs1_val;
            y_reg  <= y_val;
         end
      end else if ((state_reg == EXEC) && (cnt_reg != 4'd1)) begin
         cnt_reg <= cnt_reg - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_reg   <= '0;
         nzcv_cap_reg <= '0;
         fault_reg    <= 1'b0;
      end else if (accept) begin
         fault_reg <= 1'b0;
         if (!cmd_legal) begin
            result_reg <= '0;
         end
      end else if (capture) begin
         result_reg   <= alu_r;
         nzcv_cap_reg <= nzcv_now;
         fault_reg    <= fault_now;
      end
   end

   assign rf_we = in_wb && !illegal_reg && !fault_reg && !is_cmp_op(op_reg);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags_reg     <= '0;
         div_fault_reg <= 1'b0;
      end else begin
         if (in_wb && !illegal_reg && !fault_reg) begin
            flags_reg <= nzcv_cap_reg;
         end
         if (in_wb && fault_reg) begin
            div_fault_reg <= 1'b1;
         end else if (clr_fault) begin
            div_fault_reg <= 1'b0;
         end
      end
   end

   assign alu_opcode = op_reg;
   assign alu_x      = x_reg;
   assign alu_y      = y_reg;
   assign rsp_valid  = in_wb;
   assign rsp_err    = in_wb && (illegal_reg || fault_reg);
   assign rsp_data   = result_reg;
   assign flags_nzcv = flags_reg;
   assign div_fault  = div_fault_reg;

`ifdef ALU_ISSUE_CNT_EN
   logic [31:0] cnt_issued_reg;
   logic [15:0] cnt_faults_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_issued_reg <= '0;
         cnt_faults_reg <= '0;
      end else begin
         if (rsp_valid && (cnt_issued_reg != '1)) begin
            cnt_issued_reg <= cnt_issued_reg + 32'd1;
         end
         if (rsp_err && (cnt_faults_reg != '1)) begin
            cnt_faults_reg <= cnt_faults_reg + 16'd1;
         end
      end
   end

   assign cnt_issued = cnt_issued_reg;
   assign cnt_faults = cnt_faults_reg;
`else
   // Counter build option disabled: no statistics state or ports.
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a stand-in ALU and a
// transaction-level reference model of the register file and status.
module tb_alu_issue_ctrl;

   localparam int WIDTH  = 16;
   localparam int SETTLE = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [4:0]        cmd_opcode;
   logic [2:0]        cmd_rd, cmd_rs1, cmd_rs2;
   logic              cmd_imm_en;
   logic [WIDTH-1:0]  cmd_imm;
   logic [4:0]        alu_opcode;
   logic [WIDTH-1:0]  alu_x, alu_y, alu_r;
   logic              alu_overflow, alu_negative, alu_zero, alu_cout, alu_div_invalid;
   logic              rsp_valid;
   logic [WIDTH-1:0]  rsp_data;
   logic              rsp_err;
   logic [3:0]        flags_nzcv;
   logic              div_fault;
   logic              clr_fault;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.WIDTH(WIDTH), .ALU_SETTLE(SETTLE)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_opcode      (cmd_opcode),
      .cmd_rd          (cmd_rd),
      .cmd_rs1         (cmd_rs1),
      .cmd_rs2         (cmd_rs2),
      .cmd_imm_en      (cmd_imm_en),
      .cmd_imm         (cmd_imm),
      .alu_opcode      (alu_opcode),
      .alu_x           (alu_x),
      .alu_y           (alu_y),
      .alu_r           (alu_r),
      .alu_overflow    (alu_overflow),
      .alu_negative    (alu_negative),
      .alu_zero        (alu_zero),
      .alu_cout        (alu_cout),
      .alu_div_invalid (alu_div_invalid),
      .rsp_valid       (rsp_valid),
      .rsp_data        (rsp_data),
      .rsp_err         (rsp_err),
      .flags_nzcv      (flags_nzcv),
      .div_fault       (div_fault),
      .clr_fault       (clr_fault)
   );

   typedef struct packed {
      logic [15:0] r;
      logic n, z, c, v, dinv;
   } alu_res_t;

   typedef struct {
      int          lat;
      logic        err;
      logic [15:0] data;
      logic [3:0]  nzcv;
      logic        dfault;
      logic        ready;
   } obs_t;

   // Stand-in ALU: subtract-style ops report borrow in C
   function automatic alu_res_t alu_model(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
      alu_res_t    o;
      logic [16:0] s;
      o = '0;
      s = '0;
      case (op)
         5'd0: o.r = x;
         5'd1: begin
            s   = {1'b0, x} + {1'b0, y};
            o.r = s[15:0];
            o.c = s[16];
            o.v = (x[15] == y[15]) && (o.r[15] != x[15]);
         end
         5'd2, 5'd5, 5'd30: begin
            o.r = x - y;
            o.c = (x < y);
            o.v = (x[15] != y[15]) && (o.r[15] != x[15]);
         end
         5'd13: begin
            o.dinv = (y == 16'd0);
            o.r    = (y == 16'd0) ? 16'hFFFF : x / y;
         end
         5'd14: o.r = (y == 16'd0) ? x : x % y;
         default: o.r = x ^ (y + 16'(op));
      endcase
      o.n = o.r[15];
      o.z = (o.r == 16'd0);
      return o;
   endfunction

   alu_res_t alu_out;
   always_comb alu_out = alu_model(alu_opcode, alu_x, alu_y);
   assign alu_r           = alu_out.r;
   assign alu_negative    = alu_out.n;
   assign alu_zero        = alu_out.z;
   assign alu_cout        = alu_out.c;
   assign alu_overflow    = alu_out.v;
   assign alu_div_invalid = alu_out.dinv;

   // Reference state
   logic [15:0] m_regs [8];
   logic [3:0]  m_flags;
   logic        m_df;
   logic [4:0]  m_last_op;

   function automatic logic op_legal(input logic [4:0] op);
      int v;
      v = int'(op);
      return (v <= 16) || (v >= 24 && v <= 28) || (v == 30);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_flags   = '0;
      m_df      = 1'b0;
      m_last_op = '0;
   endtask

   task automatic model_cmd(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic imm_en, input logic [15:0] imm,
                            output obs_t e, output logic chk_data);
      logic [15:0] x, y;
      alu_res_t    a;
      logic        fault;
      x       = m_regs[rs1];
      y       = imm_en ? imm : m_regs[rs2];
      e.ready = 1'b1;
      if (!op_legal(op)) begin
         e.lat    = 1;
         e.err    = 1'b1;
         e.data   = '0;
         chk_data = 1'b1;
      end else begin
         m_last_op = op;
         a         = alu_model(op, x, y);
         e.lat     = SETTLE + 1;
         fault     = (op == 5'd13 && a.dinv) || (op == 5'd14 && y == 16'd0);
         e.err     = fault;
         e.data    = a.r;
         chk_data  = !fault;
         if (fault) begin
            m_df = 1'b1;
         end else begin
            m_flags = {a.n, a.z, a.c, a.v};
            if (op != 5'd5 && op != 5'd30 && rd != 3'd0) m_regs[rd] = a.r;
         end
      end
      e.nzcv   = m_flags;
      e.dfault = m_df;
   endtask

   // Starts and ends on a falling edge; the next call therefore issues
   // in the first IDLE cycle after WB.
   task automatic do_cmd(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic imm_en, input logic [15:0] imm,
                         output obs_t o);
      o.ready    = cmd_ready;
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_rd     = rd;
      cmd_rs1    = rs1;
      cmd_rs2    = rs2;
      cmd_imm_en = imm_en;
      cmd_imm    = imm;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      o.lat  = -1;
      o.err  = 1'bx;
      o.data = 'x;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            o.lat  = k;
            o.err  = rsp_err;
            o.data = rsp_data;
            break;
         end
      end
      @(negedge clk);
      o.nzcv   = flags_nzcv;
      o.dfault = div_fault;
      $display("txn op=%02h rd=%0d rs1=%0d rs2=%0d imm_en=%0b imm=%04h lat=%0d err=%0b data=%04h nzcv=%04b df=%0b",
               op, rd, rs1, rs2, imm_en, imm, o.lat, o.err, o.data, o.nzcv, o.dfault);
   endtask

   task automatic setreg(input logic [2:0] rd, input logic [15:0] v);
      obs_t o, e;
      logic cd;
      model_cmd(5'd1, rd, 3'd0, 3'd0, 1'b1, v, e, cd);
      do_cmd(5'd1, rd, 3'd0, 3'd0, 1'b1, v, o);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; clr_fault = 1'b0;
      cmd_opcode = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm_en = 1'b0; cmd_imm = '0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0) begin
         failures++; $display("FAIL reset_ready_low: got %b expected 0", cmd_ready);
      end
      checks++;
      if ({rsp_valid, rsp_err, rsp_data, alu_opcode, alu_x, alu_y, flags_nzcv, div_fault} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: valid=%b err=%b data=%h op=%h x=%h y=%h nzcv=%b df=%b expected all 0",
                  rsp_valid, rsp_err, rsp_data, alu_opcode, alu_x, alu_y, flags_nzcv, div_fault);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++; $display("FAIL reset_ready_after: got %b expected 1", cmd_ready);
      end
   endtask

   task automatic test_add();
      obs_t o, e;
      logic cd;
      setreg(3'd1, 16'd5);
      setreg(3'd2, 16'd3);
      model_cmd(5'd1, 3'd3, 3'd1, 3'd2, 1'b0, '0, e, cd);
      do_cmd(5'd1, 3'd3, 3'd1, 3'd2, 1'b0, '0, o);
      checks++;
      if (o.lat !== 3) begin failures++; $display("FAIL add_latency: got %0d expected 3", o.lat); end
      checks++;
      if (o.data !== 16'd8) begin failures++; $display("FAIL add_data: got %h expected 0008", o.data); end
      checks++;
      if (o.nzcv !== 4'b0000) begin failures++; $display("FAIL add_flags: got %b expected 0000", o.nzcv); end
      model_cmd(5'd0, 3'd0, 3'd3, 3'd0, 1'b0, '0, e, cd);
      do_cmd(5'd0, 3'd0, 3'd3, 3'd0, 1'b0, '0, o);
      checks++;
      if (o.data !== 16'd8) begin failures++; $display("FAIL add_r3_readback: got %h expected 0008", o.data); end
   endtask

   task automatic test_cmp();
      obs_t o, e;
      logic cd;
      setreg(3'd1, 16'd3);
      model_cmd(5'd5, 3'd7, 3'd1, 3'd2, 1'b0, '0, e, cd);
      do_cmd(5'd5, 3'd7, 3'd1, 3'd2, 1'b0, '0, o);
      checks++;
      if (o.nzcv !== 4'b0100) begin failures++; $display("FAIL cmp_flags: got %b expected 0100", o.nzcv); end
      checks++;
      if (o.data !== 16'd0 || o.err !== 1'b0) begin
         failures++; $display("FAIL cmp_rsp: data=%h err=%b expected 0000/0", o.data, o.err);
      end
      for (int i = 1; i < 8; i++) begin
         model_cmd(5'd0, 3'd0, 3'(i), 3'd0, 1'b0, '0, e, cd);
         do_cmd(5'd0, 3'd0, 3'(i), 3'd0, 1'b0, '0, o);
         checks++;
         if (o.data !== e.data) begin
            failures++; $display("FAIL cmp_reg_unchanged r%0d: got %h expected %h", i, o.data, e.data);
         end
      end
   endtask

   task automatic test_div_fault();
      obs_t o, e;
      logic cd;
      logic [3:0] flags_before;
      setreg(3'd1, 16'd10);
      setreg(3'd2, 16'd0);
      flags_before = m_flags;
      clr_fault = 1'b1;    // held through WB: the set must win
      model_cmd(5'd13, 3'd6, 3'd1, 3'd2, 1'b0, '0, e, cd);
      do_cmd(5'd13, 3'd6, 3'd1, 3'd2, 1'b0, '0, o);
      clr_fault = 1'b0;
      checks++;
      if (o.lat !== SETTLE + 1 || o.err !== 1'b1) begin
         failures++; $display("FAIL div_rsp: lat=%0d err=%b expected %0d/1", o.lat, o.err, SETTLE + 1);
      end
      checks++;
      if (o.dfault !== 1'b1) begin failures++; $display("FAIL div_fault_set: got %b expected 1", o.dfault); end
      checks++;
      if (o.nzcv !== flags_before) begin
         failures++; $display("FAIL div_flags_kept: got %b expected %b", o.nzcv, flags_before);
      end
      model_cmd(5'd0, 3'd0, 3'd6, 3'd0, 1'b0, '0, e, cd);
      do_cmd(5'd0, 3'd0, 3'd6, 3'd0, 1'b0, '0, o);
      checks++;
      if (o.data !== e.data) begin failures++; $display("FAIL div_rd_kept: got %h expected %h", o.data, e.data); end
      clr_fault = 1'b1;
      @(posedge clk);
      #1 clr_fault = 1'b0;
      m_df = 1'b0;
      @(negedge clk);
      checks++;
      if (div_fault !== 1'b0) begin failures++; $display("FAIL clr_fault: got %b expected 0", div_fault); end
      // Remainder by an immediate zero is faulted locally
      model_cmd(5'd14, 3'd6, 3'd1, 3'd0, 1'b1, 16'd0, e, cd);
      do_cmd(5'd14, 3'd6, 3'd1, 3'd0, 1'b1, 16'd0, o);
      checks++;
      if (o.err !== 1'b1 || o.dfault !== 1'b1) begin
         failures++; $display("FAIL mod_zero_fault: err=%b df=%b expected 1/1", o.err, o.dfault);
      end
   endtask

   task automatic test_illegal();
      obs_t o, e;
      logic cd;
      model_cmd(5'b11101, 3'd3, 3'd1, 3'd2, 1'b0, '0, e, cd);
      do_cmd(5'b11101, 3'd3, 3'd1, 3'd2, 1'b0, '0, o);
      checks++;
      if (o.lat !== 1 || o.err !== 1'b1 || o.data !== 16'd0) begin
         failures++; $display("FAIL illegal_rsp: lat=%0d err=%b data=%h expected 1/1/0000", o.lat, o.err, o.data);
      end
      checks++;
      if (alu_opcode !== m_last_op) begin
         failures++; $display("FAIL illegal_alu_opcode: got %h expected %h", alu_opcode, m_last_op);
      end
      checks++;
      if (o.nzcv !== e.nzcv || o.dfault !== e.dfault) begin
         failures++; $display("FAIL illegal_status: nzcv=%b df=%b expected %b/%b", o.nzcv, o.dfault, e.nzcv, e.dfault);
      end
   endtask

   task automatic test_back_to_back();
      obs_t o, e;
      logic cd;
      model_cmd(5'd1, 3'd4, 3'd1, 3'd0, 1'b1, 16'd7, e, cd);
      do_cmd(5'd1, 3'd4, 3'd1, 3'd0, 1'b1, 16'd7, o);
      checks++;
      if (o.data !== e.data) begin failures++; $display("FAIL b2b_add: got %h expected %h", o.data, e.data); end
      model_cmd(5'd0, 3'd7, 3'd4, 3'd0, 1'b0, '0, e, cd);
      do_cmd(5'd0, 3'd7, 3'd4, 3'd0, 1'b0, '0, o);
      checks++;
      if (o.ready !== 1'b1 || o.lat !== SETTLE + 1) begin
         failures++; $display("FAIL b2b_accept: ready=%b lat=%0d expected 1/%0d", o.ready, o.lat, SETTLE + 1);
      end
      checks++;
      if (o.data !== m_regs[4]) begin failures++; $display("FAIL b2b_mov: got %h expected %h", o.data, m_regs[4]); end
   endtask

   task automatic test_random();
      obs_t o, e;
      logic cd;
      logic [4:0] op;
      logic [2:0] rd, rs1, rs2;
      logic imm_en;
      logic [15:0] imm;
      for (int n = 0; n < 60; n++) begin
         op     = 5'($urandom_range(0, 31));
         rd     = 3'($urandom_range(0, 7));
         rs1    = 3'($urandom_range(0, 7));
         rs2    = 3'($urandom_range(0, 7));
         imm_en = 1'($urandom_range(0, 1));
         imm    = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
         model_cmd(op, rd, rs1, rs2, imm_en, imm, e, cd);
         do_cmd(op, rd, rs1, rs2, imm_en, imm, o);
         checks++;
         if (o.lat !== e.lat || o.err !== e.err || o.ready !== 1'b1) begin
            failures++;
            $display("FAIL rnd_rsp #%0d: lat=%0d err=%b ready=%b expected %0d/%b/1", n, o.lat, o.err, o.ready, e.lat, e.err);
         end
         checks++;
         if (cd && o.data !== e.data) begin
            failures++; $display("FAIL rnd_data #%0d: got %h expected %h", n, o.data, e.data);
         end
         checks++;
         if (o.nzcv !== e.nzcv || o.dfault !== e.dfault || alu_opcode !== m_last_op) begin
            failures++;
            $display("FAIL rnd_status #%0d: nzcv=%b df=%b op=%h expected %b/%b/%h",
                     n, o.nzcv, o.dfault, alu_opcode, e.nzcv, e.dfault, m_last_op);
         end
         if (m_df && $urandom_range(0, 1) == 1) begin
            clr_fault = 1'b1;
            @(posedge clk);
            #1 clr_fault = 1'b0;
            m_df = 1'b0;
            @(negedge clk);
         end
      end
      for (int i = 1; i < 8; i++) begin
         model_cmd(5'd0, 3'd0, 3'(i), 3'd0, 1'b0, '0, e, cd);
         do_cmd(5'd0, 3'd0, 3'(i), 3'd0, 1'b0, '0, o);
         checks++;
         if (o.data !== e.data) begin
            failures++; $display("FAIL rnd_readback r%0d: got %h expected %h", i, o.data, e.data);
         end
      end
   endtask

   task automatic test_reset_midop();
      obs_t o, e;
      logic cd;
      logic saw_valid;
      setreg(3'd1, 16'd4);
      cmd_valid = 1'b1; cmd_opcode = 5'd1; cmd_rd = 3'd5; cmd_rs1 = 3'd1;
      cmd_rs2 = 3'd0; cmd_imm_en = 1'b1; cmd_imm = 16'd9;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      saw_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) saw_valid = 1'b1;
      end
      checks++;
      if (cmd_ready !== 1'b0) begin failures++; $display("FAIL midop_ready_in_reset: got %b expected 0", cmd_ready); end
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      if (rsp_valid !== 1'b0) saw_valid = 1'b1;
      checks++;
      if (saw_valid !== 1'b0) begin failures++; $display("FAIL midop_no_rsp: got rsp_valid=1 expected 0"); end
      checks++;
      if (cmd_ready !== 1'b1) begin failures++; $display("FAIL midop_ready_after: got %b expected 1", cmd_ready); end
      model_cmd(5'd0, 3'd0, 3'd5, 3'd0, 1'b0, '0, e, cd);
      do_cmd(5'd0, 3'd0, 3'd5, 3'd0, 1'b0, '0, o);
      checks++;
      if (o.data !== 16'd0) begin failures++; $display("FAIL midop_r5: got %h expected 0000", o.data); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_cmp();
      test_div_fault();
      test_illegal();
      test_back_to_back();
      test_random();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
